// File: rtl/vend_pkg.sv
// Shared types, coin/change constants and the change-to-display-code mapping
// for the vending credit/vend controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } vend_state_t;

    localparam logic [5:0] NICKEL_C   = 6'd5;
    localparam logic [5:0] DIME_C     = 6'd10;
    localparam logic [5:0] QUARTER_C  = 6'd25;
    localparam logic [5:0] MAX_CHANGE = 6'd15;

    localparam logic [3:0] CODE_NONE = 4'd0;
    localparam logic [3:0] CODE_5    = 4'd6;
    localparam logic [3:0] CODE_10   = 4'd7;
    localparam logic [3:0] CODE_15   = 4'd8;

    // Anything other than 5/10/15 cents shows as "no change" on the display.
    function automatic logic [3:0] change_to_code(input logic [4:0] chg);
        case (chg)
            5'd5:    return CODE_5;
            5'd10:   return CODE_10;
            5'd15:   return CODE_15;
            default: return CODE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/vend_ctrl_coin_decode.sv
// Coin pulse decoder: flags a single legal coin, its value in cents, and any
// cycle where two or more coin lines are high together.
module coin_decode (
    input  logic       nickel,
    input  logic       dime,
    input  logic       quarter,
    output logic       coin_valid,
    output logic       multi_coin,
    output logic [5:0] coin_value
);
    import vend_pkg::*;

    localparam logic [2:0][5:0] COIN_VALUES = {QUARTER_C, DIME_C, NICKEL_C};

    logic [2:0]      coin_lines;
    logic [2:0][5:0] masked;

    assign coin_lines = {quarter, dime, nickel};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_coin
            assign masked[gi] = coin_lines[gi] ? COIN_VALUES[gi] : 6'd0;
        end
    endgenerate

    // coin_value is only meaningful when coin_valid is set.
    assign coin_value = masked[0] | masked[1] | masked[2];
    assign multi_coin = (nickel & dime) | (nickel & quarter) | (dime & quarter);
    assign coin_valid = (|coin_lines) & ~multi_coin;

endmodule

// File: rtl/vend_ctrl.sv
// Vending credit/vend controller: accumulates coins against PRICE, handshakes
// with the dispenser and presents change codes. Optional idle-credit
// auto-refund is enabled with the VEND_TIMEOUT_EN macro.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE          = 20,
    parameter int HOLD_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nickel,
    input  logic       dime,
    input  logic       quarter,
    input  logic       refund,
    input  logic       vend_ack,
    output logic       vend_req,
    output logic [3:0] change_code,
    output logic       change_valid,
    output logic       coin_reject,
    output logic [5:0] credit
);

    localparam int         HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam logic [6:0] PRICE_W = 7'(PRICE);
    localparam logic [6:0] LIMIT_W = 7'(PRICE) + 7'(MAX_CHANGE);

    vend_state_t       state_reg, state_next;
    logic [5:0]        credit_reg, credit_next;
    logic [4:0]        chg_reg, chg_next;
    logic              vend_req_reg, vend_req_next;
    logic [3:0]        change_code_reg, change_code_next;
    logic              change_valid_reg, change_valid_next;
    logic              coin_reject_reg, coin_reject_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;

    logic       coin_valid, multi_coin, coin_any, coin_accept;
    logic [5:0] coin_value;
    logic [6:0] coin_sum;
    logic       timeout_hit, refund_event;

    coin_decode u_coin_decode (
        .nickel     (nickel),
        .dime       (dime),
        .quarter    (quarter),
        .coin_valid (coin_valid),
        .multi_coin (multi_coin),
        .coin_value (coin_value)
    );

    assign coin_any     = nickel | dime | quarter;
    assign coin_sum     = {1'b0, credit_reg} + {1'b0, coin_value};
    assign refund_event = refund | timeout_hit;

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] timeout_reg, timeout_next;

    assign timeout_hit = (state_reg == COLLECT) &&
                         (timeout_reg == TO_W'(TIMEOUT_CYCLES - 1));

    // Counts idle cycles spent in COLLECT; any accepted coin restarts it.
    always_comb begin
        timeout_next = '0;
        if (state_reg == COLLECT && state_next == COLLECT && !coin_accept)
            timeout_next = timeout_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) timeout_reg <= '0;
        else       timeout_reg <= timeout_next;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next        = state_reg;
        credit_next       = credit_reg;
        chg_next          = chg_reg;
        vend_req_next     = vend_req_reg;
        change_code_next  = change_code_reg;
        change_valid_next = change_valid_reg;
        coin_reject_next  = 1'b0;
        hold_next         = hold_reg;
        coin_accept       = 1'b0;

        case (state_reg)
            IDLE, COLLECT: begin
                if (state_reg == COLLECT && refund_event) begin
                    chg_next          = credit_reg[4:0];
                    credit_next       = '0;
                    change_code_next  = change_to_code(credit_reg[4:0]);
                    change_valid_next = 1'b1;
                    hold_next         = '0;
                    coin_reject_next  = coin_any;
                    state_next        = CHANGE;
                end else if (multi_coin) begin
                    coin_reject_next = 1'b1;
                end else if (coin_valid) begin
                    if (coin_sum > LIMIT_W) begin
                        coin_reject_next = 1'b1;
                    end else if (coin_sum >= PRICE_W) begin
                        coin_accept   = 1'b1;
                        chg_next      = 5'(coin_sum - PRICE_W);
                        credit_next   = '0;
                        vend_req_next = 1'b1;
                        state_next    = VEND;
                    end else begin
                        coin_accept = 1'b1;
                        credit_next = coin_sum[5:0];
                        state_next  = COLLECT;
                    end
                end
            end
            VEND: begin
                coin_reject_next = coin_any;
                if (vend_ack) begin
                    vend_req_next = 1'b0;
                    if (chg_reg != 5'd0) begin
                        change_code_next  = change_to_code(chg_reg);
                        change_valid_next = 1'b1;
                        hold_next         = '0;
                        state_next        = CHANGE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            CHANGE: begin
                coin_reject_next = coin_any;
                if (hold_reg == HOLD_W'(HOLD_CYCLES - 1)) begin
                    change_code_next  = CODE_NONE;
                    change_valid_next = 1'b0;
                    chg_next          = '0;
                    hold_next         = '0;
                    state_next        = IDLE;
                end else begin
                    hold_next = hold_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            credit_reg       <= '0;
            chg_reg          <= '0;
            vend_req_reg     <= 1'b0;
            change_code_reg  <= CODE_NONE;
            change_valid_reg <= 1'b0;
            coin_reject_reg  <= 1'b0;
            hold_reg         <= '0;
        end else begin
            state_reg        <= state_next;
            credit_reg       <= credit_next;
            chg_reg          <= chg_next;
            vend_req_reg     <= vend_req_next;
            change_code_reg  <= change_code_next;
            change_valid_reg <= change_valid_next;
            coin_reject_reg  <= coin_reject_next;
            hold_reg         <= hold_next;
        end
    end

    // Only whole 5c steps up to 15c can ever be owed as change.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (chg_reg inside {5'd0, 5'd5, 5'd10, 5'd15});
            assert (HOLD_CYCLES >= 1 && TIMEOUT_CYCLES >= 1);
        end
    end

    assign vend_req     = vend_req_reg;
    assign change_code  = change_code_reg;
    assign change_valid = change_valid_reg;
    assign coin_reject  = coin_reject_reg;
    assign credit       = credit_reg;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed table-driven bench for vend_ctrl (PRICE=20, HOLD_CYCLES=8) plus
// hand-written reset and hold-length sequences.
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       nickel, dime, quarter, refund, vend_ack;
    logic       vend_req, change_valid, coin_reject;
    logic [3:0] change_code;
    logic [5:0] credit;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic       n, d, q, r, a;
        logic       er;
        logic [3:0] ec;
        logic       ev;
        logic       ej;
        logic [5:0] ecr;
    } vec_t;

    vec_t vecs[$];

    vend_ctrl #(.PRICE(20), .HOLD_CYCLES(8), .TIMEOUT_CYCLES(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .nickel       (nickel),
        .dime         (dime),
        .quarter      (quarter),
        .refund       (refund),
        .vend_ack     (vend_ack),
        .vend_req     (vend_req),
        .change_code  (change_code),
        .change_valid (change_valid),
        .coin_reject  (coin_reject),
        .credit       (credit)
    );

    always #5 clk = ~clk;

    task automatic add(input logic n, d, q, r, a, input logic er, input int ec,
                       input logic ev, input logic ej, input int ecr);
        vec_t v;
        v.n = n; v.d = d; v.q = q; v.r = r; v.a = a;
        v.er = er; v.ec = 4'(ec); v.ev = ev; v.ej = ej; v.ecr = 6'(ecr);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input vec_t v);
        vectors++;
        if (vend_req !== v.er || change_code !== v.ec || change_valid !== v.ev ||
            coin_reject !== v.ej || credit !== v.ecr) begin
            miscompares++;
            $display("FAIL %s: got req=%0b code=%0d valid=%0b rej=%0b credit=%0d, expected req=%0b code=%0d valid=%0b rej=%0b credit=%0d",
                     name, vend_req, change_code, change_valid, coin_reject, credit,
                     v.er, v.ec, v.ev, v.ej, v.ecr);
        end else begin
            $display("ok   %s: req=%0b code=%0d valid=%0b rej=%0b credit=%0d",
                     name, vend_req, change_code, change_valid, coin_reject, credit);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        nickel = v.n; dime = v.d; quarter = v.q; refund = v.r; vend_ack = v.a;
        @(posedge clk);
        #1;
        check(name, v);
    endtask

    task automatic idle_hold(input int count, input int code);
        for (int k = 0; k < count; k++) add(0, 0, 0, 0, 0, 0, code, 1, 0, 0);
    endtask

    initial begin
        vec_t v;
        int   held;

        reset = 1'b1;
        nickel = 0; dime = 0; quarter = 0; refund = 0; vend_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        v = '{n:0, d:0, q:0, r:0, a:0, er:0, ec:0, ev:0, ej:0, ecr:0};
        check("reset_state", v);
        reset = 1'b0;

        // Exact price: dime, dime, ack after 3 cycles, no change.
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 10);
        add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // Overpay: nickel + quarter -> 10c change; coins/refund ignored in VEND/CHANGE.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 7, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 7, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 7, 1, 0, 0);
        idle_hold(5, 7);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Over-limit quarter rejected at credit 15, multi-coin rejected, then refund.
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 10);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 15);
        add(0, 0, 1, 0, 0, 0, 0, 0, 1, 15);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 15);
        add(1, 1, 0, 0, 0, 0, 0, 0, 1, 15);
        add(0, 0, 0, 1, 0, 0, 8, 1, 0, 0);
        idle_hold(7, 8);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Multi-coin from IDLE.
        add(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Refund wins over a same-cycle coin.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        add(0, 1, 0, 1, 0, 0, 6, 1, 1, 0);
        idle_hold(7, 6);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Boundary: change of exactly 15c is accepted.
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 10);
        add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 8, 1, 0, 0);
        idle_hold(7, 8);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Quarter from IDLE -> 5c change.
        add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 6, 1, 0, 0);
        idle_hold(7, 6);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Four nickels hit the price exactly.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 10);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 15);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

        // Reset while vend_req is high, then a stray ack.
        v = '{n:0, d:1, q:0, r:0, a:0, er:0, ec:0, ev:0, ej:0, ecr:10};
        apply("rst_vend_dime1", v);
        v = '{n:0, d:1, q:0, r:0, a:0, er:1, ec:0, ev:0, ej:0, ecr:0};
        apply("rst_vend_dime2", v);
        reset = 1'b1;
        v = '{n:0, d:0, q:0, r:0, a:0, er:0, ec:0, ev:0, ej:0, ecr:0};
        apply("rst_vend_reset", v);
        reset = 1'b0;
        v = '{n:0, d:0, q:0, r:0, a:1, er:0, ec:0, ev:0, ej:0, ecr:0};
        apply("rst_vend_late_ack", v);
        v = '{n:1, d:0, q:0, r:0, a:0, er:0, ec:0, ev:0, ej:0, ecr:5};
        apply("rst_vend_after", v);

        // Reset while change is displayed discards it without a reject pulse.
        v = '{n:0, d:0, q:0, r:1, a:0, er:0, ec:6, ev:1, ej:0, ecr:0};
        apply("rst_chg_refund", v);
        reset = 1'b1;
        v = '{n:1, d:0, q:0, r:0, a:0, er:0, ec:0, ev:0, ej:0, ecr:0};
        apply("rst_chg_reset", v);
        reset = 1'b0;
        v = '{n:0, d:0, q:0, r:0, a:0, er:0, ec:0, ev:0, ej:0, ecr:0};
        apply("rst_chg_idle", v);

        // Measure the change hold length with a bounded wait.
        v = '{n:1, d:0, q:0, r:0, a:0, er:0, ec:0, ev:0, ej:0, ecr:5};
        apply("hold_nickel", v);
        v = '{n:0, d:0, q:1, r:0, a:0, er:1, ec:0, ev:0, ej:0, ecr:0};
        apply("hold_quarter", v);
        v = '{n:0, d:0, q:0, r:0, a:1, er:0, ec:7, ev:1, ej:0, ecr:0};
        apply("hold_ack", v);
        vend_ack = 1'b0;
        held = 0;
        for (int k = 0; k < 20; k++) begin
            if (!change_valid) break;
            held++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (held != 8) begin
            miscompares++;
            $display("FAIL hold_len: got %0d valid cycles, expected 8", held);
        end else begin
            $display("ok   hold_len: %0d valid cycles", held);
        end
        v = '{n:0, d:0, q:0, r:0, a:0, er:0, ec:0, ev:0, ej:0, ecr:0};
        check("hold_end", v);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
